divisor_kca_mmp: RTL
====================

DIVISOR_KCA_MMP -- requirements
Module: divisor_kca_mmp

Interface
REQ-001 SHALL have parameter N, default 8, meaning operand width; divisor, quotient and remainder are N bits, dividend is 2N bits.
REQ-002 SHALL have one clock and a synchronous active-high reset.
REQ-003 Clock  input  1  rising-edge clock for all state.
REQ-004 Reset  input  1  synchronous, active-high reset.
REQ-005 Start  input  1  request to begin a division, sampled only in IDLE.
REQ-006 Dividendo  input  2N  unsigned dividend, captured on accepted Start.
REQ-007 Divisor  input  N  unsigned divisor, captured on accepted Start.
REQ-008 Cociente  output  N  registered quotient of the last completed operation.
REQ-009 Residuo  output  N  registered remainder of the last completed operation.
REQ-010 Ready  output  1  high when idle and able to accept Start.
REQ-011 Error  output  1  high when the last accepted request was divide-by-zero or quotient overflow.

Function
REQ-012 SHALL implement unsigned restoring shift-subtract division as controller FSM plus datapath: partial remainder A (N+1 bits), quotient shift register Q (N bits), divisor register D (N bits), iteration counter P (ceil(log2 N)+1 bits).
REQ-013 FSM SHALL have exactly two states: IDLE and ITER; Ready = (state == IDLE), combinational from state only.
REQ-014 Start is accepted at an edge where state == IDLE and Start == 1; Start in ITER SHALL be ignored with no effect on registers.
REQ-015 Error check at acceptance: error if Divisor == 0 or Dividendo[2N-1:N] >= Divisor (quotient would not fit in N bits).
REQ-016 Accepted with error: state stays IDLE; Cociente <= all ones, Residuo <= 0, Error <= 1, all in the same edge; Ready stays 1.
REQ-017 Accepted without error: A <= {1'b0, Dividendo[2N-1:N]}, Q <= Dividendo[N-1:0], D <= Divisor, P <= N-1, state <= ITER, Error <= 0.
REQ-018 Each edge in ITER SHALL perform one step: T = {A[N-1:0], Q[N-1]}; if T >= {1'b0,D} then A <= T - D and Q <= {Q[N-2:0],1} else A <= T and Q <= {Q[N-2:0],0}.
REQ-019 In ITER, if P == 0 on the step edge: state <= IDLE, Cociente <= final Q, Residuo <= final A[N-1:0]; otherwise P <= P-1.
REQ-020 Latency: Start accepted at edge k, steps at edges k+1..k+N, results and Ready=1 visible after edge k+N; Ready low for exactly N cycles.
REQ-021 Cociente, Residuo and Error SHALL hold their values during ITER and change only at completion or on an accepted Start (Error cleared at acceptance).
REQ-022 A SHALL never exceed 2D-1 after the shift; the N+1-bit width SHALL make the comparison exact for D up to 2^N-1.
REQ-023 Back-to-back: Start high continuously yields a new acceptance on the first edge after completion (one Ready-high cycle between operations).
REQ-024 Results SHALL satisfy Dividendo == Cociente*Divisor + Residuo and Residuo < Divisor for every non-error input.

Reset
REQ-025 Reset SHALL take priority over Start and over any ITER step.
REQ-026 On Reset: state <= IDLE, A, Q, D, P <= 0, Cociente <= 0, Residuo <= 0, Error <= 0; Ready = 1 after the edge.
REQ-027 Reset during ITER SHALL abort the operation with no partial result on Cociente/Residuo.

Verification
REQ-028 Dividendo=100, Divisor=7, Start pulse -> Ready low 8 cycles, then Cociente=14, Residuo=2, Error=0.
REQ-029 Dividendo=16'hFEFF, Divisor=8'hFF -> after 8 cycles Cociente=8'hFF, Residuo=8'hFE, Error=0.
REQ-030 Divisor=0 (any dividend) and separately Dividendo=16'h0100, Divisor=1 -> Ready never falls, Error=1, Cociente=8'hFF, Residuo=0 after accepting edge.
REQ-031 Dividendo=100, Divisor=7, Reset asserted at the 4th ITER cycle -> Ready=1, Cociente=0, Residuo=0, Error=0; a following Start yields 14/2 after 8 cycles.
REQ-032 Start held high continuously with operands changed at third ITER cycle -> changed operands ignored until completion; second operation accepted one cycle after Ready rises, uses new operands.
REQ-033 Randomized self-check against REQ-024 over at least 10000 legal operand pairs plus all error cases for N=8 and N=4.

Source files
------------

// File: rtl/divisor_kca_mmp.sv
// Unsigned restoring shift-subtract divider: 2N-bit dividend by N-bit divisor,
// one quotient bit per clock, with divide-by-zero / quotient-overflow detection.
module divisor_kca_mmp #(
  parameter int unsigned N = 8
) (
  input  logic           Clock,
  input  logic           Reset,
  input  logic           Start,
  input  logic [2*N-1:0] Dividendo,
  input  logic [N-1:0]   Divisor,
  output logic [N-1:0]   Cociente,
  output logic [N-1:0]   Residuo,
  output logic           Ready,
  output logic           Error
);

  localparam int unsigned PW = $clog2(N) + 1;

  typedef enum logic {IDLE, ITER} state_t;

  state_t        state;
  logic [N:0]    a;
  logic [N-1:0]  q;
  logic [N-1:0]  d;
  logic [PW-1:0] p;

  logic [N:0]    t;
  logic [N:0]    a_step;
  logic [N-1:0]  q_step;
  logic          take;

  assign Ready = (state == IDLE);

  // a[N] is always 0 between steps (A < D); folding it into the compare keeps
  // the step correct even if that invariant were broken and uses every bit.
  always_comb begin
    t      = {a[N-1:0], q[N-1]};
    take   = a[N] | (t >= {1'b0, d});
    a_step = take ? (t - {1'b0, d}) : t;
    q_step = {q[N-2:0], take};
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state    <= IDLE;
      a        <= '0;
      q        <= '0;
      d        <= '0;
      p        <= '0;
      Cociente <= '0;
      Residuo  <= '0;
      Error    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (Start) begin
            if (Divisor == '0 || Dividendo[2*N-1:N] >= Divisor) begin
              Cociente <= '1;
              Residuo  <= '0;
              Error    <= 1'b1;
            end else begin
              a     <= {1'b0, Dividendo[2*N-1:N]};
              q     <= Dividendo[N-1:0];
              d     <= Divisor;
              p     <= PW'(N - 1);
              Error <= 1'b0;
              state <= ITER;
            end
          end
        end
        ITER: begin
          a <= a_step;
          q <= q_step;
          if (p == '0) begin
            state    <= IDLE;
            Cociente <= q_step;
            Residuo  <= a_step[N-1:0];
          end else begin
            p <= p - PW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
